// File: rtl/usb_rx_line_decoder_pkg.sv
// Shared types and constants for the USB full-speed receive line decoder.
package usb_pkg;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    K   = 2'b01,
    J   = 2'b10,
    SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_STUFF   = 2'b01,
    ERR_SE1     = 2'b10,
    ERR_BAD_EOP = 2'b11
  } rx_err_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    EOP_SE0,
    ERR
  } dec_state_t;

  localparam int MAX_ONES    = 6;
  localparam int EOP_MAX_SE0 = 2;
  localparam int IDLE_J_BITS = 8;

endpackage

// File: rtl/usb_rx_line_decoder_if.sv
// Pad-side inputs and decoded-bit outputs of the receive line decoder.
interface usb_rx_line_decoder_if;

  logic       enable;
  logic       dp_in;
  logic       dm_in;
  logic       rx_active;
  logic       bit_strobe;
  logic       bit_data;
  logic       eop;
  logic       err;
  logic [1:0] err_code;

  modport master (
    input  enable, dp_in, dm_in,
    output rx_active, bit_strobe, bit_data, eop, err, err_code
  );

  modport slave (
    output enable, dp_in, dm_in,
    input  rx_active, bit_strobe, bit_data, eop, err, err_code
  );

endinterface

// File: rtl/usb_rx_line_decoder_sync.sv
// Multi-flop synchroniser for the dp/dm pair; resets to the J (idle) state.
module usb_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= 2'b10;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/usb_rx_line_decoder.sv
// USB FS receive front end: bit timing recovery, NRZI decode, de-stuffing, EOP detect.
// Define USB_RX_DEGLITCH_EN to require two stable cycles before a new line state is accepted.
module usb_rx_line_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_STAGES  = 2
) (
  input logic                   clk,
  input logic                   n_rst,
  usb_rx_line_decoder_if.master bus
);
  import usb_pkg::*;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] SAMPLE_AT = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT  = TW'(CLKS_PER_BIT - 1);

  logic [1:0]  sync_pair;
  line_state_t line;
  line_state_t line_prev;
  logic        edge_seen;
  logic        sample;
  logic [TW-1:0] timer;

  usb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     ({bus.dp_in, bus.dm_in}),
    .q     (sync_pair)
  );

`ifdef USB_RX_DEGLITCH_EN
  logic [1:0]  sync_prev;
  line_state_t line_filt;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      sync_prev <= 2'b10;
      line_filt <= J;
    end else begin
      sync_prev <= sync_pair;
      if (sync_pair == sync_prev) line_filt <= line_state_t'(sync_pair);
    end
  end

  assign line = line_filt;
`else
  assign line = line_state_t'(sync_pair);
`endif

  assign edge_seen = (line != line_prev);
  assign sample    = (timer == SAMPLE_AT);

  // Free-running bit timer, re-phased by every line edge so samples land mid-bit.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      line_prev <= J;
      timer     <= '0;
    end else begin
      line_prev <= line;
      if (edge_seen || timer == LAST_CNT) timer <= '0;
      else                                timer <= timer + 1'b1;
    end
  end

  dec_state_t  state, state_n;
  line_state_t prev_state, prev_state_n;
  logic [2:0]  ones_cnt, ones_n;
  logic [1:0]  se0_cnt, se0_n;
  logic [3:0]  j_cnt, j_n;
  logic        strobe_q, strobe_n;
  logic        data_q, data_n;
  logic        eop_q, eop_n;
  logic        err_q, err_n;
  rx_err_t     code_q, code_n;
  logic        raw;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state      <= IDLE;
      prev_state <= J;
      ones_cnt   <= '0;
      se0_cnt    <= '0;
      j_cnt      <= '0;
      strobe_q   <= 1'b0;
      data_q     <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state      <= state_n;
      prev_state <= prev_state_n;
      ones_cnt   <= ones_n;
      se0_cnt    <= se0_n;
      j_cnt      <= j_n;
      strobe_q   <= strobe_n;
      data_q     <= data_n;
      eop_q      <= eop_n;
      err_q      <= err_n;
      code_q     <= code_n;
    end
  end

  // Pulses are computed in the sample cycle and registered, so they appear one cycle later.
  always_comb begin
    state_n      = state;
    prev_state_n = prev_state;
    ones_n       = ones_cnt;
    se0_n        = se0_cnt;
    j_n          = j_cnt;
    strobe_n     = 1'b0;
    data_n       = 1'b0;
    eop_n        = 1'b0;
    err_n        = 1'b0;
    code_n       = ERR_NONE;
    raw          = 1'b0;

    case (state)
      IDLE: begin
        if (edge_seen && line_prev == J && line == K) begin
          state_n      = ACTIVE;
          ones_n       = '0;
          prev_state_n = J;
        end
      end

      ACTIVE: begin
        if (sample) begin
          case (line)
            J, K: begin
              raw          = (line == prev_state);
              prev_state_n = line;
              if (ones_cnt == 3'(MAX_ONES)) begin
                if (raw) begin
                  state_n = ERR;
                  err_n   = 1'b1;
                  code_n  = ERR_STUFF;
                  j_n     = '0;
                end else begin
                  ones_n = '0;
                end
              end else begin
                strobe_n = 1'b1;
                data_n   = raw;
                ones_n   = raw ? ones_cnt + 3'd1 : 3'd0;
              end
            end
            SE0: begin
              state_n = EOP_SE0;
              se0_n   = 2'd1;
            end
            default: begin
              state_n = ERR;
              err_n   = 1'b1;
              code_n  = ERR_SE1;
              j_n     = '0;
            end
          endcase
        end
      end

      EOP_SE0: begin
        if (sample) begin
          if (line == SE0 && se0_cnt != 2'(EOP_MAX_SE0)) begin
            se0_n = se0_cnt + 2'd1;
          end else if (line == J) begin
            state_n = IDLE;
            eop_n   = 1'b1;
          end else begin
            state_n = ERR;
            err_n   = 1'b1;
            code_n  = ERR_BAD_EOP;
            j_n     = '0;
          end
        end
      end

      default: begin
        // Leave ERR only after the bus has shown a run of idle J bits.
        if (sample) begin
          if (line != J) begin
            j_n = '0;
          end else if (j_cnt == 4'(IDLE_J_BITS - 1)) begin
            state_n = IDLE;
            j_n     = '0;
          end else begin
            j_n = j_cnt + 4'd1;
          end
        end
      end
    endcase

    if (!bus.enable) begin
      state_n  = IDLE;
      strobe_n = 1'b0;
      data_n   = 1'b0;
      eop_n    = 1'b0;
      err_n    = 1'b0;
      code_n   = ERR_NONE;
    end
  end

  assign bus.rx_active  = (state == ACTIVE) || (state == EOP_SE0);
  assign bus.bit_strobe = strobe_q;
  assign bus.bit_data   = data_q;
  assign bus.eop        = eop_q;
  assign bus.err        = err_q;
  assign bus.err_code   = code_q;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Self-checking bench: random packets are NRZI-encoded with stuffing and the decoded bits compared.
module tb_usb_rx_line_decoder;

  localparam int CPB = 8;
  localparam logic [1:0] L_SE0 = 2'b00;
  localparam logic [1:0] L_K   = 2'b01;
  localparam logic [1:0] L_J   = 2'b10;
  localparam logic [1:0] L_SE1 = 2'b11;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;

  usb_rx_line_decoder_if bus();

  usb_rx_line_decoder #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Monitor: sole writer of the observation record; tests take snapshots of it.
  bit         got_q[$];
  int         eop_tot = 0;
  int         err_tot = 0;
  int         clash_tot = 0;
  int         active_tot = 0;
  logic [1:0] last_code = 2'b00;

  always @(negedge clk) begin
    if (bus.bit_strobe === 1'b1) got_q.push_back(bus.bit_data);
    if (bus.eop === 1'b1) begin
      eop_tot++;
      if (bus.rx_active !== 1'b0 || bus.err !== 1'b0) clash_tot++;
    end
    if (bus.err === 1'b1) begin
      err_tot++;
      last_code = bus.err_code;
      if (bus.rx_active !== 1'b0) clash_tot++;
    end
    if (bus.bit_strobe === 1'b1 && (bus.eop === 1'b1 || bus.err === 1'b1)) clash_tot++;
    if (bus.rx_active === 1'b1) active_tot++;
  end

  // Packet builder: line symbols to drive plus the bit stream a correct decoder must emit.
  logic [1:0] sym_q[$];
  bit [255:0] exp_vec;
  int         exp_len;
  logic [1:0] enc_cur;
  int         enc_ones;

  function automatic void clear_pkt();
    sym_q.delete();
    exp_vec  = '0;
    exp_len  = 0;
    enc_cur  = L_J;
    enc_ones = 0;
  endfunction

  function automatic void push_exp(bit b);
    if (exp_len < 256) exp_vec[exp_len] = b;
    exp_len++;
  endfunction

  function automatic void add_sym(logic [1:0] s);
    sym_q.push_back(s);
  endfunction

  function automatic void add_bit(bit b);
    if (!b) begin
      enc_cur  = (enc_cur == L_J) ? L_K : L_J;
      enc_ones = 0;
    end else begin
      enc_ones++;
    end
    sym_q.push_back(enc_cur);
    push_exp(b);
    if (enc_ones == 6) begin
      enc_cur  = (enc_cur == L_J) ? L_K : L_J;
      enc_ones = 0;
      sym_q.push_back(enc_cur);
    end
  endfunction

  function automatic void add_sync();
    for (int i = 0; i < 7; i++) add_bit(1'b0);
    add_bit(1'b1);
  endfunction

  function automatic void add_random(int n);
    for (int i = 0; i < n; i++) add_bit(1'($urandom_range(1, 0)));
  endfunction

  function automatic void add_eop();
    add_sym(L_SE0);
    add_sym(L_SE0);
    add_sym(L_J);
    enc_cur  = L_J;
    enc_ones = 0;
  endfunction

  function automatic void add_idle(int n);
    for (int i = 0; i < n; i++) add_sym(L_J);
  endfunction

  function automatic bit [255:0] got_since(int start);
    bit [255:0] v = '0;
    for (int i = start; i < got_q.size(); i++)
      if (i - start < 256) v[i - start] = got_q[i];
    return v;
  endfunction

  task automatic drive_pkt(input int p_even, input int p_odd);
    for (int i = 0; i < sym_q.size(); i++) begin
      int per = (i % 2 == 0) ? p_even : p_odd;
      for (int c = 0; c < per; c++) begin
        @(posedge clk); #1;
        if (c == 0) {bus.dp_in, bus.dm_in} = sym_q[i];
      end
    end
  endtask

  task automatic test_reset();
    int s_st, s_eop, s_err, s_act;
    n_rst = 1'b1;
    bus.enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      {bus.dp_in, bus.dm_in} = 2'($urandom_range(3, 0));
      @(negedge clk);
      checks++;
      if ({bus.rx_active, bus.bit_strobe, bus.bit_data, bus.eop, bus.err, bus.err_code} !== 7'b0)
        $display("[TB] FAIL reset_outputs cycle %0d: got %b, want 0000000", c,
                 {bus.rx_active, bus.bit_strobe, bus.bit_data, bus.eop, bus.err, bus.err_code});
      else passes++;
    end
    {bus.dp_in, bus.dm_in} = L_J;
    @(posedge clk); #1;
    n_rst = 1'b0;
    s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot; s_act = active_tot;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (active_tot - s_act != 0)
      $display("[TB] FAIL reset_release_active: got %0d active cycles, want 0", active_tot - s_act);
    else passes++;
    checks++;
    if ((got_q.size() - s_st) + (eop_tot - s_eop) + (err_tot - s_err) != 0)
      $display("[TB] FAIL reset_release_pulses: got %0d strobes %0d eop %0d err, want 0 0 0",
               got_q.size() - s_st, eop_tot - s_eop, err_tot - s_err);
    else passes++;
  endtask

  task automatic test_sync_eop();
    int s_st, s_eop, s_err, s_cl, s_act;
    bit [255:0] got;
    clear_pkt(); add_sync(); add_eop(); add_idle(3);
    s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot; s_cl = clash_tot; s_act = active_tot;
    drive_pkt(CPB, CPB);
    got = got_since(s_st);
    checks++;
    if (got_q.size() - s_st != exp_len || got !== exp_vec)
      $display("[TB] FAIL sync_bits: got %0d bits %h, want %0d bits %h",
               got_q.size() - s_st, got, exp_len, exp_vec);
    else passes++;
    checks++;
    if (eop_tot - s_eop != 1 || err_tot - s_err != 0)
      $display("[TB] FAIL sync_eop_count: got eop %0d err %0d, want eop 1 err 0",
               eop_tot - s_eop, err_tot - s_err);
    else passes++;
    checks++;
    if (clash_tot - s_cl != 0)
      $display("[TB] FAIL sync_eop_overlap: got %0d overlaps, want 0", clash_tot - s_cl);
    else passes++;
    checks++;
    if (active_tot - s_act < 8 * CPB)
      $display("[TB] FAIL sync_rx_active: got %0d active cycles, want at least %0d",
               active_tot - s_act, 8 * CPB);
    else passes++;
    checks++;
    if (bus.rx_active !== 1'b0)
      $display("[TB] FAIL sync_idle_after: got rx_active %b, want 0", bus.rx_active);
    else passes++;
  endtask

  task automatic test_stuff_error();
    int s_st, s_eop, s_err, s_cl;
    bit [255:0] got;
    clear_pkt(); add_sync();
    for (int i = 0; i < 5; i++) push_exp(1'b1);
    for (int i = 0; i < 7; i++) add_sym(L_K);
    add_idle(12);
    s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot; s_cl = clash_tot;
    drive_pkt(CPB, CPB);
    got = got_since(s_st);
    checks++;
    if (got_q.size() - s_st != exp_len || got !== exp_vec)
      $display("[TB] FAIL stuff_err_bits: got %0d bits %h, want %0d bits %h",
               got_q.size() - s_st, got, exp_len, exp_vec);
    else passes++;
    checks++;
    if (err_tot - s_err != 1 || eop_tot - s_eop != 0)
      $display("[TB] FAIL stuff_err_count: got err %0d eop %0d, want err 1 eop 0",
               err_tot - s_err, eop_tot - s_eop);
    else passes++;
    checks++;
    if (last_code !== 2'b01)
      $display("[TB] FAIL stuff_err_code: got %b, want 01", last_code);
    else passes++;
    checks++;
    if (clash_tot - s_cl != 0)
      $display("[TB] FAIL stuff_err_overlap: got %0d overlaps, want 0", clash_tot - s_cl);
    else passes++;
  endtask

  task automatic test_stuffed_zero();
    int s_st, s_eop, s_err;
    bit [255:0] got;
    clear_pkt(); add_sync();
    for (int i = 0; i < 7; i++) add_bit(1'b1);
    add_eop(); add_idle(3);
    s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot;
    drive_pkt(CPB, CPB);
    got = got_since(s_st);
    checks++;
    if (got_q.size() - s_st != exp_len || got !== exp_vec)
      $display("[TB] FAIL stuffed_zero_bits: got %0d bits %h, want %0d bits %h",
               got_q.size() - s_st, got, exp_len, exp_vec);
    else passes++;
    checks++;
    if (eop_tot - s_eop != 1 || err_tot - s_err != 0)
      $display("[TB] FAIL stuffed_zero_eop: got eop %0d err %0d, want eop 1 err 0",
               eop_tot - s_eop, err_tot - s_err);
    else passes++;
  endtask

  task automatic test_drift();
    int s_st, s_eop, s_err;
    bit [255:0] got;
    clear_pkt(); add_sync(); add_random(40); add_eop(); add_idle(3);
    s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot;
    drive_pkt(CPB - 1, CPB + 1);
    got = got_since(s_st);
    checks++;
    if (got_q.size() - s_st != exp_len || got !== exp_vec)
      $display("[TB] FAIL drift_bits: got %0d bits %h, want %0d bits %h",
               got_q.size() - s_st, got, exp_len, exp_vec);
    else passes++;
    checks++;
    if (eop_tot - s_eop != 1 || err_tot - s_err != 0)
      $display("[TB] FAIL drift_eop: got eop %0d err %0d, want eop 1 err 0",
               eop_tot - s_eop, err_tot - s_err);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int s_st, s_eop, s_err, s_cl;
    bit [255:0] got;
    clear_pkt();
    for (int p = 0; p < 3; p++) begin
      add_sync(); add_random($urandom_range(30, 1)); add_eop(); add_idle(1);
    end
    add_idle(2);
    s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot; s_cl = clash_tot;
    drive_pkt(CPB, CPB);
    got = got_since(s_st);
    checks++;
    if (got_q.size() - s_st != exp_len || got !== exp_vec)
      $display("[TB] FAIL b2b_bits: got %0d bits %h, want %0d bits %h",
               got_q.size() - s_st, got, exp_len, exp_vec);
    else passes++;
    checks++;
    if (eop_tot - s_eop != 3 || err_tot - s_err != 0)
      $display("[TB] FAIL b2b_eop: got eop %0d err %0d, want eop 3 err 0",
               eop_tot - s_eop, err_tot - s_err);
    else passes++;
    checks++;
    if (clash_tot - s_cl != 0)
      $display("[TB] FAIL b2b_overlap: got %0d overlaps, want 0", clash_tot - s_cl);
    else passes++;
  endtask

  task automatic test_se1_fault();
    int s_st, s_eop, s_err;
    bit [255:0] got;
    clear_pkt(); add_sync(); add_random($urandom_range(10, 2));
    add_sym(L_SE1); add_idle(12);
    s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot;
    drive_pkt(CPB, CPB);
    got = got_since(s_st);
    checks++;
    if (got_q.size() - s_st != exp_len || got !== exp_vec)
      $display("[TB] FAIL se1_bits: got %0d bits %h, want %0d bits %h",
               got_q.size() - s_st, got, exp_len, exp_vec);
    else passes++;
    checks++;
    if (err_tot - s_err != 1 || eop_tot - s_eop != 0)
      $display("[TB] FAIL se1_count: got err %0d eop %0d, want err 1 eop 0",
               err_tot - s_err, eop_tot - s_eop);
    else passes++;
    checks++;
    if (last_code !== 2'b10)
      $display("[TB] FAIL se1_code: got %b, want 10", last_code);
    else passes++;
  endtask

  task automatic test_bad_eop();
    int s_st, s_eop, s_err;
    bit [255:0] got;
    for (int v = 0; v < 2; v++) begin
      clear_pkt(); add_sync(); add_random($urandom_range(10, 1));
      add_sym(L_SE0);
      if (v == 0) begin
        add_sym(L_SE0); add_sym(L_SE0);
      end else begin
        add_sym(L_K);
      end
      add_idle(12);
      s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot;
      drive_pkt(CPB, CPB);
      got = got_since(s_st);
      checks++;
      if (got_q.size() - s_st != exp_len || got !== exp_vec)
        $display("[TB] FAIL bad_eop_bits v%0d: got %0d bits %h, want %0d bits %h",
                 v, got_q.size() - s_st, got, exp_len, exp_vec);
      else passes++;
      checks++;
      if (err_tot - s_err != 1 || eop_tot - s_eop != 0)
        $display("[TB] FAIL bad_eop_count v%0d: got err %0d eop %0d, want err 1 eop 0",
                 v, err_tot - s_err, eop_tot - s_eop);
      else passes++;
      checks++;
      if (last_code !== 2'b11)
        $display("[TB] FAIL bad_eop_code v%0d: got %b, want 11", v, last_code);
      else passes++;
    end
  endtask

  task automatic test_enable_low();
    int s_st, s_eop, s_err, s_act;
    clear_pkt(); add_sync(); add_random(20); add_eop(); add_idle(3);
    s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot; s_act = active_tot;
    fork
      drive_pkt(CPB, CPB);
      begin
        repeat (18 * CPB + 3) @(posedge clk);
        #2;
        checks++;
        if (bus.rx_active !== 1'b1)
          $display("[TB] FAIL enable_pre_drop_active: got %b, want 1", bus.rx_active);
        else passes++;
        bus.enable = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (bus.rx_active !== 1'b0)
          $display("[TB] FAIL enable_drop_active: got %b, want 0", bus.rx_active);
        else passes++;
        s_st = got_q.size(); s_eop = eop_tot; s_err = err_tot; s_act = active_tot;
      end
    join
    checks++;
    if ((got_q.size() - s_st) + (eop_tot - s_eop) + (err_tot - s_err) != 0)
      $display("[TB] FAIL enable_low_pulses: got %0d strobes %0d eop %0d err, want 0 0 0",
               got_q.size() - s_st, eop_tot - s_eop, err_tot - s_err);
    else passes++;
    checks++;
    if (active_tot - s_act != 0)
      $display("[TB] FAIL enable_low_active: got %0d active cycles, want 0", active_tot - s_act);
    else passes++;
    bus.enable = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  initial begin
    bus.enable = 1'b1;
    {bus.dp_in, bus.dm_in} = L_J;
    clear_pkt();
    $display("[TB] start");
    test_reset();
    test_sync_eop();
    test_stuff_error();
    test_stuffed_zero();
    test_drift();
    test_back_to_back();
    test_se1_fault();
    test_bad_eop();
    test_enable_low();
    test_sync_eop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
